env_detect: RTL and testbench
=============================

ENV_DETECT -- requirements
Module: env_detect

Interface
REQ-001 Parameter W, default 12: sample and envelope width in bits, range 8..24.
REQ-002 Parameter SMOOTH_SHIFT, default 4: smoothing filter shift K, range 1..8; used only with ENV_SMOOTH_EN.
REQ-003 i_clk  input  1  single clock for all logic, rising-edge.
REQ-004 i_rst  input  1  reset: asynchronous, active-low.
REQ-005 in_valid  input  1  sample_i, sample_q and mode are valid this cycle.
REQ-006 sample_i  input  W  in-phase sample, two's complement.
REQ-007 sample_q  input  W  quadrature sample, two's complement.
REQ-008 mode  input  2  coefficient select, captured with in_valid.
REQ-009 out_valid  output  1  out holds a new envelope value this cycle.
REQ-010 out  output  W  envelope estimate, unsigned.

Function
REQ-011 No backpressure: a sample is accepted on every cycle in_valid=1, including back-to-back cycles.
REQ-012 Stage 1 registers |sample_i| and |sample_q| as W-bit unsigned values; the most negative input maps to 2^(W-1) with no wrap.
REQ-013 Stage 2 registers mx=max(|I|,|Q|) and mn=min(|I|,|Q|); equal magnitudes give mx=mn.
REQ-014 Stage 3 computes est = a*mx + b*mn with shift-add only (no multipliers): mode 0: a=1, b=3/8; mode 1: a=1, b=1/2; mode 2: a=15/16, b=15/32; mode 3: a=1, b=1/4.
REQ-015 Each shifted term truncates (floors) on its own before summing; intermediate width is W+1 bits.
REQ-016 est always fits in W bits (magnitude <= 2^(W-1), coefficient sum <= 1.5); out = est[W-1:0].
REQ-017 mode travels down the pipeline with its sample; a mode change affects only samples accepted with the new mode.
REQ-018 Latency in_valid to out_valid: exactly 3 cycles without smoothing; valid is a 3-deep shift register.
REQ-019 out holds its last value while out_valid=0.

Reset
REQ-020 While i_rst=0: all valid flags, all pipeline registers, out and the smoothing accumulator are 0, asynchronously.
REQ-021 Reset asserted mid-stream drops every sample in flight; after release the first out_valid is 3 (4) cycles after the first accepted in_valid.

Configuration
REQ-022 Macro ENV_SMOOTH_EN compiled in: stage 4 adds a one-pole filter y <= y + ((est - y) >>> SMOOTH_SHIFT) (signed difference, arithmetic shift) that updates only on stage-3 valid, and out = new y; latency 4 cycles.
REQ-023 ENV_SMOOTH_EN compiled out: no stage 4, no accumulator, out = est, latency 3 cycles; SMOOTH_SHIFT is ignored.
REQ-024 The filter accumulator is W bits unsigned and cannot overflow or underflow, because y stays between previous y and est.

Structure
REQ-025 Shared package env_pkg holds the mode encoding constants (MODE_3_8, MODE_1_2, MODE_15_16, MODE_1_4) and the latency constants for both builds.
REQ-026 Sub-module env_abs, a registered W-bit two's-complement magnitude unit, is instantiated twice in stage 1.

Verification (W=12, SMOOTH_SHIFT=4)
REQ-027 I=300, Q=-400, mode 0, single valid -> after 3 cycles out=512 (400 + floor(300*3/8)=112), out_valid high for 1 cycle.
REQ-028 I=-2048, Q=-2048, modes 1 then 2 on back-to-back cycles -> out=3072, then out=2880 on consecutive cycles.
REQ-029 I=0, Q=-2048, mode 3 -> out=2048; I=Q=0 -> out=0; no wrap on the most negative input.
REQ-030 Valid bursts 1,1,0,1 -> out_valid pattern 1,1,0,1 delayed by exactly 3 cycles; out holds its value in the gap.
REQ-031 Reset pulse while 2 samples are in flight -> out=0, out_valid=0 immediately; neither sample emerges after reset release.
REQ-032 ENV_SMOOTH_EN, constant est=512 from reset -> out=32, then 62, then 90, converging monotonically to 512 at latency 4.

Source files
------------

// File: rtl/env_pkg.sv
// rtl/env_pkg.sv - shared mode encodings and latency constants for env_detect
// Optional build macro: ENV_SMOOTH_EN selects the smoothed-output latency.
package env_pkg;

    localparam logic [1:0] MODE_3_8   = 2'd0;
    localparam logic [1:0] MODE_1_2   = 2'd1;
    localparam logic [1:0] MODE_15_16 = 2'd2;
    localparam logic [1:0] MODE_1_4   = 2'd3;

    localparam int LAT_BASE   = 3;
    localparam int LAT_SMOOTH = 4;

`ifdef ENV_SMOOTH_EN
    localparam int LATENCY = LAT_SMOOTH;
`else
    localparam int LATENCY = LAT_BASE;
`endif

endpackage

// File: rtl/env_abs.sv
// rtl/env_abs.sv - registered two's-complement magnitude, W-bit unsigned result
// The most negative input yields 2^(W-1), which fits the unsigned result without wrap.
module env_abs
    import env_pkg::*;
#(
    parameter int W = 12
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_en,
    input  logic [W-1:0] i_x,
    output logic [W-1:0] o_mag
);

    logic [W-1:0] r_mag;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_mag <= '0;
        end else if (i_en) begin
            r_mag <= i_x[W-1] ? (~i_x + W'(1)) : i_x;
        end
    end

    assign o_mag = r_mag;

endmodule

// File: rtl/env_detect.sv
// rtl/env_detect.sv - alpha-max/beta-min envelope detector, 3-stage pipeline
// Optional build macro: ENV_SMOOTH_EN adds a one-pole smoothing stage (latency 4).
module env_detect
    import env_pkg::*;
#(
    parameter int W            = 12,
    parameter int SMOOTH_SHIFT = 4
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         in_valid,
    input  logic [W-1:0] sample_i,
    input  logic [W-1:0] sample_q,
    input  logic [1:0]   mode,
    output logic         out_valid,
    output logic [W-1:0] out
);

    logic [W-1:0] w_mag_i;
    logic [W-1:0] w_mag_q;
    logic         r_v1;
    logic [1:0]   r_m1;
    logic         r_v2;
    logic [1:0]   r_m2;
    logic [W-1:0] r_mx;
    logic [W-1:0] r_mn;
    logic [W:0]   w_mx;
    logic [W:0]   w_mn;
    logic [W:0]   w_est;

    // Stage 1: magnitudes, with valid and mode riding alongside
    env_abs #(.W(W)) u_abs_i (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_en  (in_valid),
        .i_x   (sample_i),
        .o_mag (w_mag_i)
    );

    env_abs #(.W(W)) u_abs_q (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_en  (in_valid),
        .i_x   (sample_q),
        .o_mag (w_mag_q)
    );

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_v1 <= 1'b0;
            r_m1 <= '0;
        end else begin
            r_v1 <= in_valid;
            if (in_valid) begin
                r_m1 <= mode;
            end
        end
    end

    // Stage 2: sort magnitudes into max/min
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_v2 <= 1'b0;
            r_m2 <= '0;
            r_mx <= '0;
            r_mn <= '0;
        end else begin
            r_v2 <= r_v1;
            if (r_v1) begin
                r_m2 <= r_m1;
                if (w_mag_i >= w_mag_q) begin
                    r_mx <= w_mag_i;
                    r_mn <= w_mag_q;
                end else begin
                    r_mx <= w_mag_q;
                    r_mn <= w_mag_i;
                end
            end
        end
    end

    // Stage 3 arithmetic: every shifted term floors independently before the sum
    assign w_mx = {1'b0, r_mx};
    assign w_mn = {1'b0, r_mn};

    always_comb begin
        w_est = w_mx;
        case (r_m2)
            MODE_3_8:   w_est = w_mx + (w_mn >> 2) + (w_mn >> 3);
            MODE_1_2:   w_est = w_mx + (w_mn >> 1);
            MODE_15_16: w_est = w_mx - (w_mx >> 4) + (w_mn >> 1) - (w_mn >> 5);
            MODE_1_4:   w_est = w_mx + (w_mn >> 2);
            default:    w_est = w_mx;
        endcase
    end

`ifdef ENV_SMOOTH_EN
    logic                r_v3;
    logic [W-1:0]        r_est;
    logic                r_v4;
    logic [W-1:0]        r_y;
    logic signed [W:0]   w_diff;
    logic signed [W:0]   w_step;
    logic signed [W:0]   w_y_next;
    logic                w_unused_bits;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_v3  <= 1'b0;
            r_est <= '0;
        end else begin
            r_v3 <= r_v2;
            if (r_v2) begin
                r_est <= w_est[W-1:0];
            end
        end
    end

    // y moves a fraction of the way toward est, so it never leaves [y, est]
    assign w_diff   = $signed({1'b0, r_est}) - $signed({1'b0, r_y});
    assign w_step   = w_diff >>> SMOOTH_SHIFT;
    assign w_y_next = $signed({1'b0, r_y}) + w_step;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_v4 <= 1'b0;
            r_y  <= '0;
        end else begin
            r_v4 <= r_v3;
            if (r_v3) begin
                r_y <= w_y_next[W-1:0];
            end
        end
    end

    assign w_unused_bits = w_est[W] ^ w_y_next[W];
    assign out           = r_y;
    assign out_valid     = r_v4;
`else
    logic         r_v3;
    logic [W-1:0] r_out;
    logic         w_unused_bits;

    localparam int unused_smooth_shift = SMOOTH_SHIFT;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_v3  <= 1'b0;
            r_out <= '0;
        end else begin
            r_v3 <= r_v2;
            if (r_v2) begin
                r_out <= w_est[W-1:0];
            end
        end
    end

    assign w_unused_bits = w_est[W];
    assign out           = r_out;
    assign out_valid     = r_v3;
`endif

endmodule

// File: tb/tb_env_detect.sv
// tb/tb_env_detect.sv - self-checking bench for env_detect (W=12, SMOOTH_SHIFT=4)
// Optional build macro: ENV_SMOOTH_EN switches the model and pinned values to the smoothed build.
module tb_env_detect;

    localparam int W = 12;
    localparam int K = 4;
`ifdef ENV_SMOOTH_EN
    localparam int  LAT    = 4;
    localparam bit  SMOOTH = 1'b1;
`else
    localparam int  LAT    = 3;
    localparam bit  SMOOTH = 1'b0;
`endif

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic [W-1:0] sample_i;
    logic [W-1:0] sample_q;
    logic [1:0]   mode;
    logic         out_valid;
    logic [W-1:0] out;

    env_detect #(.W(W), .SMOOTH_SHIFT(K)) dut (
        .i_clk     (clk),
        .i_rst     (rst_n),
        .in_valid  (in_valid),
        .sample_i  (sample_i),
        .sample_q  (sample_q),
        .mode      (mode),
        .out_valid (out_valid),
        .out       (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int due;
        int val;
        int lit;
    } exp_t;

    exp_t q_exp[$];
    int   cyc     = 0;
    int   checks  = 0;
    int   errors  = 0;
    int   exp_out = 0;
    int   y_model = 0;
    int   cur_lit = -1;
    int   cur_i   = 0;
    int   cur_q   = 0;
    int   cur_m   = 0;

    // Envelope from the coefficient table, using integer floors per term
    function automatic int model_est(input int si, input int sq, input int m);
        int ai, aq, mx, mn;
        ai = (si < 0) ? -si : si;
        aq = (sq < 0) ? -sq : sq;
        mx = (ai > aq) ? ai : aq;
        mn = (ai > aq) ? aq : ai;
        case (m)
            0:       return mx + mn / 4 + mn / 8;
            1:       return mx + mn / 2;
            2:       return mx - mx / 16 + mn / 2 - mn / 32;
            default: return mx + mn / 4;
        endcase
    endfunction

    function automatic int pin(input int v);
        return SMOOTH ? -1 : v;
    endfunction

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, req);
        end
    endtask

    // Model capture: every accepted sample becomes an expected output LAT-1 edges later
    always @(posedge clk) begin
        cyc++;
        if (rst_n && in_valid) begin
            exp_t e;
            int   est;
            est = model_est(cur_i, cur_q, cur_m);
            if (SMOOTH) begin
                y_model = y_model + ((est - y_model) >>> K);
                e.val = y_model;
            end else begin
                e.val = est;
            end
            e.due = cyc + LAT - 1;
            e.lit = cur_lit;
            q_exp.push_back(e);
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            check("reset_out", int'(out), 0);
            check("reset_valid", int'(out_valid), 0);
        end else begin
            bit ev;
            ev = (q_exp.size() > 0) && (q_exp[0].due == cyc);
            check("out_valid", int'(out_valid), int'(ev));
            if (ev) begin
                exp_out = q_exp[0].val;
                if (q_exp[0].lit >= 0)
                    check("pinned_out", int'(out), q_exp[0].lit);
                void'(q_exp.pop_front());
            end
            check("out", int'(out), exp_out);
        end
    end

    task automatic step(input bit v, input int si, input int sq, input int m, input int lit);
        @(posedge clk);
        #1;
        in_valid = v;
        sample_i = si[W-1:0];
        sample_q = sq[W-1:0];
        mode     = m[1:0];
        cur_i    = si;
        cur_q    = sq;
        cur_m    = m;
        cur_lit  = lit;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 0, 0, 0, -1);
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        q_exp.delete();
        exp_out = 0;
        y_model = 0;
    endtask

    initial begin
        int vec_i [6] = '{1000, -1, -1500, 2047, -333, 64};
        int vec_q [6] = '{-999, 0, 700, -2048, -334, 2000};
        in_valid = 1'b0;
        sample_i = '0;
        sample_q = '0;
        mode     = 2'd0;
        do_reset();
        idle(3);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Constant est=512 straight out of reset
        step(1'b1, 300, -400, 0, SMOOTH ? 32 : 512);
        step(1'b1, 300, -400, 0, SMOOTH ? 62 : 512);
        step(1'b1, 300, -400, 0, SMOOTH ? 90 : 512);
        idle(1);

        step(1'b1, 300, -400, 0, pin(512));
        idle(4);

        step(1'b1, -2048, -2048, 1, pin(3072));
        step(1'b1, -2048, -2048, 2, pin(2880));
        step(1'b1, 0, -2048, 3, pin(2048));
        step(1'b1, 0, 0, 0, pin(0));
        idle(4);

        // Burst 1,1,0,1 with a hold in the gap
        step(1'b1, 100, -50, 1, pin(125));
        step(1'b1, -7, 7, 2, pin(10));
        step(1'b0, 5, 5, 3, -1);
        step(1'b1, 2047, -1, 0, pin(2047));
        idle(4);

        for (int k = 0; k < 6; k++) begin
            step(1'b1, vec_i[k], vec_q[k], k % 4, -1);
            if (k == 2) idle(1);
        end
        idle(5);

        // Reset with two samples in flight
        step(1'b1, 1234, 321, 1, -1);
        step(1'b1, -999, 888, 2, -1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        do_reset();
        #1;
        check("reset_now_out", int'(out), 0);
        check("reset_now_valid", int'(out_valid), 0);
        idle(2);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(6);

        step(1'b1, 300, -400, 0, SMOOTH ? 32 : 512);
        idle(7);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
